// File: rtl/dp_pkg.sv
// Shared types and encodings for the multi-cycle datapath: FSM states,
// ALU operation codes and the RV32 opcodes the immediate generator decodes.
package dp_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/alu.sv
// XLEN-wide ALU; shifts take their amount from a separate field so that
// immediate shifts work regardless of the second operand.
module alu import dp_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [5:0]      shamt,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  logic [5:0] shamt_s;

  // Operation select
  always_comb begin
    shamt_s = (XLEN == 64) ? shamt : {1'b0, shamt[4:0]};
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << shamt_s;
      ALU_SRL:  y = a >> shamt_s;
      ALU_SRA:  y = $signed(a) >>> shamt_s;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      default:  y = {XLEN{1'b0}};
    endcase
  end

  assign zero = (y == {XLEN{1'b0}});

endmodule

// File: rtl/mc_datapath_imm_gen.sv
// Immediate generator: picks the I, S or B layout from the opcode and
// sign-extends it to XLEN.
module imm_gen import dp_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm
);

  // Format decode
  always_comb begin
    case (ir[6:0])
      OP_LOAD, OP_IMM: imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
      OP_STORE:        imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:       imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default:         imm = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/regfile.sv
// Two-read, one-write register file; entry 0 reads as zero and ignores writes.
module regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_r [NUM_REGS];

  // Storage with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= {XLEN{1'b0}};
    end else if (we && (waddr != {AW{1'b0}})) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[raddr1];
  assign rdata2 = (raddr2 == {AW{1'b0}}) ? {XLEN{1'b0}} : regs_r[raddr2];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: FETCH/DECODE/EXEC/MEM/WB with a MEM timeout into HALT.
// Define RETIRE_CNT_EN to build the saturating retired-instruction counter.
module mc_datapath import dp_pkg::*; #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] INITIAL_PC  = 32'h00400000,
  parameter int              NUM_REGS    = 32,
  parameter int              MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            iValid,
  output logic            fetchReq,
  output logic [XLEN-1:0] PC,
  input  logic [3:0]      ALUCtrl,
  input  logic            ALUSrc,
  input  logic            RegWrite,
  input  logic            MemToReg,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            Branch,
  output logic [XLEN-1:0] dAddress,
  output logic [XLEN-1:0] dWriteData,
  input  logic [XLEN-1:0] dReadData,
  output logic            dReq,
  input  logic            dAck,
  output logic            Zero,
  output logic [XLEN-1:0] WriteBackData,
  output logic            memErr,
  output logic [63:0]     instret
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  state_t          state_r;
  logic [31:0]     ir_r;
  logic [XLEN-1:0] pc_r, a_r, b_r, imm_r, alu_out_r, mdr_r, wb_data_r;
  logic [4:0]      rd_r;
  logic [3:0]      alu_ctrl_r;
  logic            alu_src_r, reg_write_r, mem_to_reg_r, mem_read_r, mem_write_r, branch_r;
  logic            fetch_req_r, dreq_r, mem_err_r, zero_r;
  logic [CW-1:0]   mem_cnt_r;

  logic [XLEN-1:0] imm_s, rdata1_s, rdata2_s, op2_s, alu_res_s, wb_data_s;
  logic            zero_s, rf_we_s;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (.ir(ir_r), .imm(imm_s));

  regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .AW(AW)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we_s),
    .waddr  (rd_r[AW-1:0]),
    .wdata  (wb_data_s),
    .raddr1 (ir_r[15 +: AW]),
    .rdata1 (rdata1_s),
    .raddr2 (ir_r[20 +: AW]),
    .rdata2 (rdata2_s)
  );

  assign op2_s = alu_src_r ? imm_r : b_r;

  alu #(.XLEN(XLEN)) u_alu (
    .op    (alu_ctrl_r),
    .a     (a_r),
    .b     (op2_s),
    .shamt (imm_r[5:0]),
    .y     (alu_res_s),
    .zero  (zero_s)
  );

  assign wb_data_s = mem_to_reg_r ? mdr_r : alu_out_r;
  assign rf_we_s   = (state_r == WB) && reg_write_r && (rd_r != 5'd0);

  // Control FSM and all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FETCH;
      pc_r         <= INITIAL_PC;
      ir_r         <= 32'd0;
      a_r          <= {XLEN{1'b0}};
      b_r          <= {XLEN{1'b0}};
      imm_r        <= {XLEN{1'b0}};
      alu_out_r    <= {XLEN{1'b0}};
      mdr_r        <= {XLEN{1'b0}};
      wb_data_r    <= {XLEN{1'b0}};
      rd_r         <= 5'd0;
      alu_ctrl_r   <= 4'd0;
      alu_src_r    <= 1'b0;
      reg_write_r  <= 1'b0;
      mem_to_reg_r <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      branch_r     <= 1'b0;
      fetch_req_r  <= 1'b0;
      dreq_r       <= 1'b0;
      mem_err_r    <= 1'b0;
      zero_r       <= 1'b0;
      mem_cnt_r    <= {CW{1'b0}};
    end else begin
      case (state_r)
        FETCH: begin
          if (iValid) begin
            ir_r        <= instr;
            fetch_req_r <= 1'b0;
            state_r     <= DECODE;
          end else begin
            fetch_req_r <= 1'b1;
          end
        end
        DECODE: begin
          rd_r         <= ir_r[11:7];
          a_r          <= rdata1_s;
          b_r          <= rdata2_s;
          imm_r        <= imm_s;
          alu_ctrl_r   <= ALUCtrl;
          alu_src_r    <= ALUSrc;
          reg_write_r  <= RegWrite;
          mem_to_reg_r <= MemToReg;
          mem_read_r   <= MemRead;
          mem_write_r  <= MemWrite;
          branch_r     <= Branch;
          state_r      <= EXEC;
        end
        EXEC: begin
          alu_out_r <= alu_res_s;
          zero_r    <= zero_s;
          // Branches resolve here and retire without a WB cycle
          if (branch_r) begin
            pc_r        <= zero_s ? (pc_r + imm_r) : (pc_r + PC_STEP);
            fetch_req_r <= 1'b1;
            state_r     <= FETCH;
          end else if (mem_read_r || mem_write_r) begin
            dreq_r    <= 1'b1;
            mem_cnt_r <= {CW{1'b0}};
            state_r   <= MEM;
          end else begin
            state_r <= WB;
          end
        end
        MEM: begin
          // A dAck on the final allowed cycle still wins over the timeout
          if (dAck) begin
            mdr_r   <= dReadData;
            dreq_r  <= 1'b0;
            state_r <= WB;
          end else if (mem_cnt_r == CW'(MEM_TIMEOUT - 1)) begin
            mem_err_r <= 1'b1;
            dreq_r    <= 1'b0;
            state_r   <= HALT;
          end else begin
            mem_cnt_r <= mem_cnt_r + CW'(1'b1);
          end
        end
        WB: begin
          wb_data_r   <= wb_data_s;
          pc_r        <= pc_r + PC_STEP;
          fetch_req_r <= 1'b1;
          state_r     <= FETCH;
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

`ifdef RETIRE_CNT_EN
  logic [63:0] instret_r;

  // Saturating retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_r <= 64'd0;
    end else if (((state_r == WB) || ((state_r == EXEC) && branch_r)) && (instret_r != {64{1'b1}})) begin
      instret_r <= instret_r + 64'd1;
    end
  end

  assign instret = instret_r;
`else
  assign instret = 64'd0;
`endif

  assign fetchReq      = fetch_req_r;
  assign PC            = pc_r;
  assign dAddress      = alu_out_r;
  assign dWriteData    = b_r;
  assign dReq          = dreq_r;
  assign Zero          = zero_r;
  assign WriteBackData = wb_data_r;
  assign memErr        = mem_err_r;

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: expectations are queued at issue and
// compared when the datapath returns to FETCH or halts.
module tb_mc_datapath;

  localparam logic [31:0] INIT_PC = 32'h00400000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        iValid;
  logic        fetchReq;
  logic [31:0] PC;
  logic [3:0]  ALUCtrl;
  logic        ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, Branch;
  logic [31:0] dAddress, dWriteData, dReadData;
  logic        dReq, dAck, Zero, memErr;
  logic [31:0] WriteBackData;
  logic [63:0] instret;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] wb;
    int          lat;
    logic        err;
    logic [63:0] ret;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] ret_cnt = 64'd0;

  mc_datapath dut (
    .clk(clk), .rst(rst), .instr(instr), .iValid(iValid), .fetchReq(fetchReq), .PC(PC),
    .ALUCtrl(ALUCtrl), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .dAddress(dAddress), .dWriteData(dWriteData), .dReadData(dReadData),
    .dReq(dReq), .dAck(dAck), .Zero(Zero), .WriteBackData(WriteBackData),
    .memErr(memErr), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_ret();
`ifdef RETIRE_CNT_EN
    return ret_cnt;
`else
    return 64'd0;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    iValid = 1'b0;
    dAck = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_pc", {32'd0, PC}, {32'd0, INIT_PC});
    check_eq("rst_fetchreq", {63'd0, fetchReq}, 64'd0);
    check_eq("rst_dreq", {63'd0, dReq}, 64'd0);
    check_eq("rst_memerr", {63'd0, memErr}, 64'd0);
    check_eq("rst_wb", {32'd0, WriteBackData}, 64'd0);
    check_eq("rst_instret", instret, 64'd0);
    ret_cnt = 64'd0;
    rst = 1'b0;
  endtask

  // ctl = {ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, Branch}
  task automatic drive(input logic [31:0] ins, input logic [3:0] op, input logic [5:0] ctl);
    int w;
    w = 0;
    while (!fetchReq && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_eq("fetch_wait", {63'd0, fetchReq}, 64'd1);
    instr = ins;
    iValid = 1'b1;
    ALUCtrl = op;
    {ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, Branch} = ctl;
  endtask

  task automatic run_instr(input string name, input logic [31:0] ins, input logic [3:0] op,
                           input logic [5:0] ctl, input logic [31:0] e_pc, input logic [31:0] e_wb,
                           input int e_lat, input int ack_delay, input logic [31:0] rdata,
                           input logic [31:0] e_addr, input logic [31:0] e_wdata, input logic e_err);
    exp_t e;
    int   lat, waited;
    bit   seen, acked, done;
    drive(ins, op, ctl);
    if (!e_err) ret_cnt++;
    e.pc = e_pc; e.wb = e_wb; e.lat = e_lat; e.err = e_err; e.ret = exp_ret();
    exp_q.push_back(e);
    lat = 0; waited = 0; seen = 0; acked = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      lat++;
      iValid = 1'b0;
      if (dReq && !acked) begin
        if (!seen) begin
          seen = 1;
          check_eq({name, "_daddr"}, {32'd0, dAddress}, {32'd0, e_addr});
          check_eq({name, "_dwdata"}, {32'd0, dWriteData}, {32'd0, e_wdata});
        end
        if (waited == ack_delay) begin
          dAck = 1'b1;
          dReadData = rdata;
          acked = 1;
        end else begin
          waited++;
        end
      end else begin
        dAck = 1'b0;
      end
      if (fetchReq || memErr) done = 1;
    end
    dAck = 1'b0;
    check_eq({name, "_done"}, {63'd0, done}, 64'd1);
    e = exp_q.pop_front();
    check_eq({name, "_pc"}, {32'd0, PC}, {32'd0, e.pc});
    check_eq({name, "_wb"}, {32'd0, WriteBackData}, {32'd0, e.wb});
    check_eq({name, "_lat"}, 64'(lat), 64'(e.lat));
    check_eq({name, "_memerr"}, {63'd0, memErr}, {63'd0, e.err});
    check_eq({name, "_instret"}, instret, e.ret);
  endtask

  initial begin
    instr = 32'd0; ALUCtrl = 4'd0; dReadData = 32'd0;
    {ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, Branch} = 6'b0;
    do_reset();

    run_instr("addi_x1", 32'h00500093, 4'd0, 6'b110000, 32'h00400004, 32'd5, 4, 0, 32'd0, 32'd0, 32'd0, 1'b0);
    run_instr("addi_x0", 32'h00700013, 4'd0, 6'b110000, 32'h00400008, 32'd7, 4, 0, 32'd0, 32'd0, 32'd0, 1'b0);
    run_instr("add_x3_x0", 32'h000001B3, 4'd0, 6'b010000, 32'h0040000C, 32'd0, 4, 0, 32'd0, 32'd0, 32'd0, 1'b0);
    run_instr("slli_x4", 32'h00309213, 4'd5, 6'b110000, 32'h00400010, 32'd40, 4, 0, 32'd0, 32'd0, 32'd0, 1'b0);
    run_instr("beq_taken", 32'hFE000CE3, 4'd1, 6'b000001, 32'h00400008, 32'd40, 3, 0, 32'd0, 32'd0, 32'd0, 1'b0);
    check_eq("beq_zero", {63'd0, Zero}, 64'd1);
    run_instr("beq_nt", 32'hFE008CE3, 4'd1, 6'b000001, 32'h0040000C, 32'd40, 3, 0, 32'd0, 32'd0, 32'd0, 1'b0);
    check_eq("beq_nt_zero", {63'd0, Zero}, 64'd0);
    run_instr("sw_x1", 32'h00102623, 4'd0, 6'b100010, 32'h00400010, 32'd12, 7, 2, 32'd0, 32'd12, 32'd5, 1'b0);
    run_instr("lw_late_ack", 32'h00002103, 4'd0, 6'b111100, 32'h00400014, 32'h12345678, 20, 15, 32'h12345678, 32'd0, 32'd0, 1'b0);
    run_instr("add_x5", 32'h001102B3, 4'd0, 6'b010000, 32'h00400018, 32'h1234567D, 4, 0, 32'd0, 32'd0, 32'd0, 1'b0);
    run_instr("sub_x7", 32'h401283B3, 4'd1, 6'b010000, 32'h0040001C, 32'h12345678, 4, 0, 32'd0, 32'd0, 32'd0, 1'b0);
    run_instr("lw_timeout", 32'h00002103, 4'd0, 6'b111100, 32'h0040001C, 32'h12345678, 19, 1000, 32'hDEADBEEF, 32'd0, 32'd0, 1'b1);

    // HALT must hold with no requests
    repeat (5) @(negedge clk);
    check_eq("halt_fetchreq", {63'd0, fetchReq}, 64'd0);
    check_eq("halt_dreq", {63'd0, dReq}, 64'd0);
    check_eq("halt_memerr", {63'd0, memErr}, 64'd1);
    do_reset();

    // Reset in the second MEM cycle of a load
    drive(32'h00002103, 4'd0, 6'b111100);
    @(negedge clk);
    iValid = 1'b0;
    for (int i = 0; i < 10 && !dReq; i++) @(negedge clk);
    check_eq("mid_mem_dreq_seen", {63'd0, dReq}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_mem_dreq_drop", {63'd0, dReq}, 64'd0);
    check_eq("mid_mem_pc", {32'd0, PC}, {32'd0, INIT_PC});
    rst = 1'b0;
    ret_cnt = 64'd0;
    run_instr("add_x6_x2", 32'h00010333, 4'd0, 6'b010000, 32'h00400004, 32'd0, 4, 0, 32'd0, 32'd0, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
